// File: rtl/sa_pkg.sv
// Shared types and constants for the classifier result collector.
package sa_pkg;

    // Classifier rule id width; the result entry layout depends on it.
    localparam int RULE_ID_W = 14;

    // Source lane encoding stored with every result.
    localparam logic LANE_1 = 1'b0;
    localparam logic LANE_2 = 1'b1;

    // One buffered result: {lane, hit, rule_id} = 16 bits.
    typedef struct packed {
        logic                 lane;
        logic                 hit;
        logic [RULE_ID_W-1:0] rule_id;
    } result_t;

    localparam int RESULT_W = $bits(result_t);

    // Build an entry; a miss carries no meaningful rule id, so store zero.
    function automatic result_t make_result(input logic lane,
                                            input logic hit,
                                            input logic [RULE_ID_W-1:0] id);
        result_t r;
        r.lane    = lane;
        r.hit     = hit;
        r.rule_id = hit ? id : '0;
        return r;
    endfunction

endpackage

// File: rtl/sa_sat_counter.sv
// Saturating statistics counter: adds 0..2 per cycle, synchronous clear wins
// over a same-cycle increment, sticks at all-ones.
module sa_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   sum;

    // Next count: clear, saturate on carry-out, or plain add.
    always_comb begin
        sum   = {1'b0, cnt_q} + {{(CNT_W-1){1'b0}}, inc};
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (sum[CNT_W]) begin
            cnt_d = '1;
        end else begin
            cnt_d = sum[CNT_W-1:0];
        end
    end

    // Counter register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/sa_result_collector.sv
// Merges the two classifier result lanes into one ordered stream, buffers it
// in a 2-write/1-read FIFO with valid/ready output, and keeps hit/miss/drop
// statistics. Inputs cannot be stalled, so results that do not fit are dropped.
module sa_result_collector
    import sa_pkg::*;
#(
    parameter int RULE_ID_W = sa_pkg::RULE_ID_W,   // must match the package entry layout
    parameter int DEPTH     = 16,                  // power of two, >= 4
    parameter int CNT_W     = 32
) (
    input  logic                       clk,
    input  logic                       RSTn,
    input  logic [RULE_ID_W-1:0]       rule_id1,
    input  logic                       data_valid1,
    input  logic                       action_valid1,
    input  logic [RULE_ID_W-1:0]       rule_id2,
    input  logic                       data_valid2,
    input  logic                       action_valid2,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [RULE_ID_W-1:0]       res_rule_id,
    output logic                       res_hit,
    output logic                       res_lane,
    output logic [$clog2(DEPTH):0]     fifo_level,
    input  logic                       clr_stats,
    output logic [CNT_W-1:0]           hit_cnt,
    output logic [CNT_W-1:0]           miss_cnt,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Storage and pointers
    result_t          mem_q [DEPTH];
    result_t          mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;

    // Per-cycle write decision
    logic             pop;
    logic [LVL_W:0]   avail;
    logic             wr1, wr2;
    logic [PTR_W-1:0] addr2;
    logic [1:0]       n_written;
    logic [1:0]       hit_inc, miss_inc, drop_inc;
    result_t          entry1, entry2, head;

    assign res_valid = (level_q != '0);
    assign pop       = res_valid & res_ready;

    // Decide which lanes fit: lane 1 claims the first free slot, lane 2 the next.
    always_comb begin
        entry1    = make_result(LANE_1, action_valid1, rule_id1);
        entry2    = make_result(LANE_2, action_valid2, rule_id2);
        // A same-cycle pop frees one slot for this cycle's writes.
        avail     = (LVL_W+1)'(DEPTH) - {1'b0, level_q} + (LVL_W+1)'(pop);
        wr1       = data_valid1 && (avail != '0);
        wr2       = data_valid2 && (avail > (LVL_W+1)'(wr1));
        addr2     = wr_ptr_q + PTR_W'(wr1);
        n_written = {1'b0, wr1} + {1'b0, wr2};
        hit_inc   = {1'b0, wr1 & action_valid1}  + {1'b0, wr2 & action_valid2};
        miss_inc  = {1'b0, wr1 & ~action_valid1} + {1'b0, wr2 & ~action_valid2};
        drop_inc  = {1'b0, data_valid1 & ~wr1}   + {1'b0, data_valid2 & ~wr2};
    end

    // Next storage contents: write accepted entries at their slots.
    always_comb begin
        mem_d = mem_q;
        if (wr1) begin
            mem_d[wr_ptr_q] = entry1;
        end
        if (wr2) begin
            mem_d[addr2] = entry2;
        end
    end

    // Next pointer, level and sticky overflow state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(n_written);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        level_d    = level_q + LVL_W'(n_written) - LVL_W'(pop);
        overflow_d = overflow_q;
        if (clr_stats) begin
            overflow_d = 1'b0;
        end else if (drop_inc != 2'd0) begin
            overflow_d = 1'b1;
        end
    end

    // Entry storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control registers; reset empties the FIFO immediately.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Head is read straight from storage; zeroed while empty so stale or
    // uninitialised entries never show on the outputs.
    always_comb begin
        head        = mem_q[rd_ptr_q];
        res_rule_id = '0;
        res_hit     = 1'b0;
        res_lane    = 1'b0;
        if (res_valid) begin
            res_rule_id = head.rule_id;
            res_hit     = head.hit;
            res_lane    = head.lane;
        end
    end

    assign fifo_level = level_q;
    assign overflow   = overflow_q;

    sa_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst_n (RSTn),
        .clr   (clr_stats),
        .inc   (hit_inc),
        .cnt   (hit_cnt)
    );

    sa_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst_n (RSTn),
        .clr   (clr_stats),
        .inc   (miss_inc),
        .cnt   (miss_cnt)
    );

    sa_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rst_n (RSTn),
        .clr   (clr_stats),
        .inc   (drop_inc),
        .cnt   (drop_cnt)
    );

endmodule

// File: tb/tb_sa_result_collector.sv
// Directed bench for sa_result_collector with a scoreboard queue of expected results.
module tb_sa_result_collector;

    localparam int RID_W = 14;
    localparam int DEPTH = 16;
    localparam int CNT_W = 32;

    logic             clk;
    logic             RSTn;
    logic [RID_W-1:0] rule_id1, rule_id2;
    logic             data_valid1, action_valid1, data_valid2, action_valid2;
    logic             res_valid, res_ready, res_hit, res_lane;
    logic [RID_W-1:0] res_rule_id;
    logic [4:0]       fifo_level;
    logic             clr_stats;
    logic [CNT_W-1:0] hit_cnt, miss_cnt, drop_cnt;
    logic             overflow;

    sa_result_collector #(.RULE_ID_W(RID_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .RSTn          (RSTn),
        .rule_id1      (rule_id1),
        .data_valid1   (data_valid1),
        .action_valid1 (action_valid1),
        .rule_id2      (rule_id2),
        .data_valid2   (data_valid2),
        .action_valid2 (action_valid2),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_rule_id   (res_rule_id),
        .res_hit       (res_hit),
        .res_lane      (res_lane),
        .fifo_level    (fifo_level),
        .clr_stats     (clr_stats),
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt),
        .drop_cnt      (drop_cnt),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Scoreboard: expected {lane, hit, rule_id} in output order.
    logic [15:0] sb[$];
    longint      m_hit, m_miss, m_drop;
    bit          m_ovf;
    bit          stall_prev;
    logic [15:0] held;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic longint sat_add(input longint a, input int b);
        longint s = a + b;
        return (s > 64'h0000_0000_FFFF_FFFF) ? 64'h0000_0000_FFFF_FFFF : s;
    endfunction

    task automatic model_reset();
        sb.delete();
        m_hit = 0; m_miss = 0; m_drop = 0; m_ovf = 0;
        stall_prev = 0;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
    task automatic step(input bit dv1, input bit av1, input int id1,
                        input bit dv2, input bit av2, input int id2,
                        input bit rdy, input bit clr);
        int avail;
        int hits, misses, drops;
        data_valid1 = dv1; action_valid1 = av1; rule_id1 = RID_W'(id1);
        data_valid2 = dv2; action_valid2 = av2; rule_id2 = RID_W'(id2);
        res_ready = rdy; clr_stats = clr;
        @(negedge clk);
        check("valid", res_valid, sb.size() != 0);
        check("level", fifo_level, sb.size());
        if (sb.size() != 0) check("head", {res_lane, res_hit, res_rule_id}, sb[0]);
        if (stall_prev) check("stable", {res_lane, res_hit, res_rule_id}, held);
        check("hit_cnt", hit_cnt, m_hit);
        check("miss_cnt", miss_cnt, m_miss);
        check("drop_cnt", drop_cnt, m_drop);
        check("overflow", overflow, m_ovf);
        stall_prev = (sb.size() != 0) && !rdy;
        if (sb.size() != 0) held = sb[0];
        if (sb.size() != 0 && rdy) void'(sb.pop_front());
        avail = DEPTH - sb.size();
        hits = 0; misses = 0; drops = 0;
        if (dv1) begin
            if (avail > 0) begin
                sb.push_back({1'b0, av1, av1 ? RID_W'(id1) : RID_W'(0)});
                avail--;
                if (av1) hits++; else misses++;
            end else drops++;
        end
        if (dv2) begin
            if (avail > 0) begin
                sb.push_back({1'b1, av2, av2 ? RID_W'(id2) : RID_W'(0)});
                if (av2) hits++; else misses++;
            end else drops++;
        end
        if (clr) begin
            m_hit = 0; m_miss = 0; m_drop = 0; m_ovf = 0;
        end else begin
            m_hit  = sat_add(m_hit, hits);
            m_miss = sat_add(m_miss, misses);
            m_drop = sat_add(m_drop, drops);
            if (drops != 0) m_ovf = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 0, 0, 0, 0, rdy, 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, res_valid, 1'b0);
        check({tag, "_level"}, fifo_level, 0);
        check({tag, "_hit_cnt"}, hit_cnt, 0);
        check({tag, "_miss_cnt"}, miss_cnt, 0);
        check({tag, "_drop_cnt"}, drop_cnt, 0);
        check({tag, "_overflow"}, overflow, 1'b0);
        check({tag, "_res_data"}, {res_lane, res_hit, res_rule_id}, 16'h0);
    endtask

    initial begin
        RSTn = 1'b0;
        rule_id1 = '0; rule_id2 = '0;
        data_valid1 = 0; action_valid1 = 0; data_valid2 = 0; action_valid2 = 0;
        res_ready = 0; clr_stats = 0;
        held = '0;
        model_reset();

        // Power-on reset held for 5 cycles
        repeat (5) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        RSTn = 1'b1;
        @(posedge clk);
        #1;

        // Dual push with consumer ready: lane 1 then lane 2
        step(1, 1, 3817, 1, 1, 4562, 1, 0);
        idle(1);
        idle(1);
        idle(1);
        check("dual_hit_cnt", hit_cnt, 2);

        // Miss on lane 1 stores rule id 0
        step(1, 0, 4457, 0, 0, 0, 1, 0);
        check("miss_level", fifo_level, 1);
        check("miss_rule_id", res_rule_id, 0);
        check("miss_hit", res_hit, 1'b0);
        idle(1);
        check("miss_cnt_one", miss_cnt, 1);

        // action_valid without data_valid is ignored
        step(0, 1, 77, 0, 1, 88, 1, 0);
        idle(1);

        // Fill under backpressure, then overflow with avail = 0
        for (int i = 0; i < 8; i++) step(1, 1, 100 + 2 * i, 1, (i % 2) == 0, 101 + 2 * i, 0, 0);
        step(1, 1, 900, 1, 1, 901, 0, 0);
        idle(0);
        check("full_level", fifo_level, 16);
        check("full_drop_cnt", drop_cnt, 2);
        check("full_overflow", overflow, 1'b1);
        idle(1);
        step(1, 1, 910, 1, 0, 911, 1, 0);       // avail = 2 via same-cycle pop
        idle(1);
        step(1, 0, 920, 1, 1, 921, 0, 0);       // avail = 1: lane 2 dropped
        for (int i = 0; i < 20; i++) idle(1);
        check("drain_level", fifo_level, 0);

        // Ordering with ready toggling
        for (int i = 0; i < 10; i++) step(1, 1, 2000 + 2 * i, 1, (i % 3) != 0, 2001 + 2 * i, (i % 2) == 0, 0);
        for (int i = 0; i < 60 && sb.size() != 0; i++) idle((i % 2) == 0);
        check("toggle_drained", sb.size(), 0);
        idle(1);

        // clr_stats with a simultaneous hit push: counters and flag clear, entry still stored
        step(1, 1, 300, 0, 0, 0, 0, 1);
        idle(0);
        check("clr_hit_cnt", hit_cnt, 0);
        check("clr_overflow", overflow, 1'b0);
        check("clr_level", fifo_level, 1);
        step(1, 1, 301, 1, 0, 302, 0, 0);
        step(1, 1, 303, 1, 1, 304, 1, 0);

        // Asynchronous reset in the middle of a cycle
        data_valid1 = 0; data_valid2 = 0;
        #2 RSTn = 1'b0;
        #1;
        check_reset_state("async_reset");
        model_reset();
        @(negedge clk);
        RSTn = 1'b1;
        @(posedge clk);
        #1;
        step(0, 0, 0, 1, 1, 555, 1, 0);
        idle(1);
        idle(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
